// File: rtl/pulse_decoder_pkg.sv
// Shared types and constants for the 3-to-8 pulse decoder.
// Imported by pulse_timer and pulse_decoder_3to8.
package pulse_decoder_pkg;

  localparam int CODE_W  = 3;
  localparam int OUT_W   = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  function automatic logic [OUT_W-1:0] onehot(
    input logic [CODE_W-1:0] code
  );
    logic [OUT_W-1:0] o;
    o       = '0;
    o[code] = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable 8-bit down-counter with zero flag.
// Priority: clear over load over dec.
module pulse_timer
  import pulse_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_decoder_3to8.sv
// Registered 3-to-8 one-hot pulse decoder with dead time and event count.
// Optional odd-parity check on accepted codes: PULSE_DECODER_PARITY_CHK_EN.
module pulse_decoder_3to8
  import pulse_decoder_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
`ifdef PULSE_DECODER_PARITY_CHK_EN
  input  logic              in_parity,
  output logic              parity_err,
`endif
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  event_cnt
);

  localparam logic [TIMER_W-1:0] PULSE_M1 =
    TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] GAP_M1 =
    (GAP_LEN == 0) ? '0 : TIMER_W'(GAP_LEN - 1);

  state_t             state;
  state_t             state_n;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_n;
  logic [OUT_W-1:0]   out_n;
  logic               accept;
  logic               parity_ok;
  logic               start;
  logic               t_clear;
  logic               t_load;
  logic               t_dec;
  logic [TIMER_W-1:0] t_val;
  logic               t_zero;

  assign in_ready = enable && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

`ifdef PULSE_DECODER_PARITY_CHK_EN
  assign parity_ok = ^{in_parity, in_code};
`else
  assign parity_ok = 1'b1;
`endif

  // A rejected code is still consumed; it just never starts a pulse.
  assign start = accept && parity_ok;

  pulse_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (t_clear),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_n = state;
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_val   = '0;
    if (!enable) begin
      state_n = IDLE;
      t_clear = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = ACTIVE;
            t_load  = 1'b1;
            t_val   = PULSE_M1;
          end
        end
        ACTIVE: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if (GAP_LEN == 0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            t_load  = 1'b1;
            t_val   = GAP_M1;
          end
        end
        GAP: begin
          if (t_zero) state_n = IDLE;
          else        t_dec   = 1'b1;
        end
        default: begin
          state_n = IDLE;
          t_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    code_n = start ? in_code : code_q;
    out_n  = '0;
    if (state_n == ACTIVE) out_n = onehot(code_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      code_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      event_cnt <= '0;
    end else begin
      state     <= state_n;
      code_q    <= code_n;
      out       <= out_n;
      out_valid <= |out_n;
      if (start) event_cnt <= event_cnt + CNT_W'(1);
    end
  end

`ifdef PULSE_DECODER_PARITY_CHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= accept && !parity_ok;
  end
`endif

endmodule

// File: tb/tb_pulse_decoder_3to8.sv
// Scoreboard bench for pulse_decoder_3to8 (4/1/16 and 1/0/4 builds).
// Parity checks are included when PULSE_DECODER_PARITY_CHK_EN is set.
module tb_pulse_decoder_3to8;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [2:0]  in_code;
  logic        in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        busy;
  logic [15:0] event_cnt;

  logic        enable2;
  logic        in_valid2;
  logic [2:0]  code2;
  logic        ready2;
  logic [7:0]  out2;
  logic        ov2;
  logic        busy2;
  logic [3:0]  cnt2;

`ifdef PULSE_DECODER_PARITY_CHK_EN
  logic in_parity;
  logic parity_err;
  logic bad_par;
  logic parity2;
  logic perr2;
  assign in_parity = bad_par ? ^in_code : ~^in_code;
  assign parity2   = ~^code2;
`endif

  always #5 clk = ~clk;

  pulse_decoder_3to8 #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_code    (in_code),
`ifdef PULSE_DECODER_PARITY_CHK_EN
    .in_parity  (in_parity),
    .parity_err (parity_err),
`endif
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .event_cnt  (event_cnt)
  );

  pulse_decoder_3to8 #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(4)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable2),
    .in_valid   (in_valid2),
    .in_code    (code2),
`ifdef PULSE_DECODER_PARITY_CHK_EN
    .in_parity  (parity2),
    .parity_err (perr2),
`endif
    .in_ready   (ready2),
    .out        (out2),
    .out_valid  (ov2),
    .busy       (busy2),
    .event_cnt  (cnt2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0]  o;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] mdl_cnt;
  int          len;
  logic        pv;
  bit          trunc = 1'b0;
  logic        par_ok;

`ifdef PULSE_DECODER_PARITY_CHK_EN
  assign par_ok = ^{in_parity, in_code};
`else
  assign par_ok = 1'b1;
`endif

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      mdl_cnt = '0;
      len     = 0;
      pv      = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_out", {24'd0, out}, {24'd0, e.o});
          chk("sb_cnt", {16'd0, event_cnt}, {16'd0, e.c});
        end
        len = 1;
      end else if (out_valid) begin
        len++;
      end else if (pv && !trunc) begin
        chk("pulse_len", len, PL);
      end
      pv = out_valid;
      if (in_valid && in_ready && par_ok) begin
        mdl_cnt++;
        sb.push_back('{o: 8'h01 << in_code, c: mdl_cnt});
      end
    end
  end

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy && w < 40) begin
      tick();
      w++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nlow;
    int w;
    int last;
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    enable2   = 1'b0;
    in_valid2 = 1'b0;
    code2     = '0;
`ifdef PULSE_DECODER_PARITY_CHK_EN
    bad_par   = 1'b0;
`endif
    last = 0;
    repeat (3) tick();
    chk("rst_out", {24'd0, out}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, event_cnt}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);

    reset  = 1'b0;
    enable = 1'b1;
    tick();
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    // single code 5
    in_code  = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("c5_out", {24'd0, out}, 32'h20);
    chk("c5_busy", {31'd0, busy}, 32'd1);
    chk("c5_cnt", {16'd0, event_cnt}, 32'd1);
    nlow = 0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      nlow++;
      tick();
    end
    chk("c5_ready_low", nlow, 5);
    chk("c5_out_end", {24'd0, out}, 32'd0);

    // walk codes 0..7 with in_valid held
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_code = k[2:0];
      w = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      chk("walk_wait", {31'd0, in_ready}, 32'd1);
      tick();
      if (k > 0) chk("walk_period", cyc - last, 6);
      last = cyc;
    end
    in_valid = 1'b0;
    wait_idle("walk_idle");
    chk("walk_cnt", {16'd0, event_cnt}, 32'd9);

    // truncate code 2 with enable
    in_code  = 3'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("tr_mid", {24'd0, out}, 32'h04);
    enable = 1'b0;
    trunc  = 1'b1;
    tick();
    chk("tr_out", {24'd0, out}, 32'd0);
    chk("tr_ov", {31'd0, out_valid}, 32'd0);
    chk("tr_busy", {31'd0, busy}, 32'd0);
    chk("tr_cnt", {16'd0, event_cnt}, 32'd10);
    in_valid = 1'b1;
    chk("dis_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) tick();
    chk("dis_out", {24'd0, out}, 32'd0);
    chk("dis_cnt", {16'd0, event_cnt}, 32'd10);
    in_valid = 1'b0;
    tick();
    trunc  = 1'b0;
    enable = 1'b1;
    tick();

    // async reset mid-pulse
    in_code  = 3'd6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_pre", {24'd0, out}, 32'h40);
    #2 reset = 1'b1;
    #1;
    chk("ar_out", {24'd0, out}, 32'd0);
    chk("ar_ov", {31'd0, out_valid}, 32'd0);
    chk("ar_cnt", {16'd0, event_cnt}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    in_code  = 3'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ar_resume", {24'd0, out}, 32'h80);
    chk("ar_cnt1", {16'd0, event_cnt}, 32'd1);
    wait_idle("ar_idle");
    tick();

`ifdef PULSE_DECODER_PARITY_CHK_EN
    bad_par  = 1'b1;
    in_code  = 3'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bad_par  = 1'b0;
    chk("par_err", {31'd0, parity_err}, 32'd1);
    chk("par_out", {24'd0, out}, 32'd0);
    chk("par_busy", {31'd0, busy}, 32'd0);
    chk("par_cnt", {16'd0, event_cnt}, 32'd1);
    tick();
    chk("par_err_clr", {31'd0, parity_err}, 32'd0);
    chk("par_out2", {24'd0, out}, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("par_good", {24'd0, out}, 32'h02);
    chk("par_gcnt", {16'd0, event_cnt}, 32'd2);
    chk("par_noerr", {31'd0, parity_err}, 32'd0);
    wait_idle("par_idle");
    chk("par2_err", {31'd0, perr2}, 32'd0);
`endif

    // single-cycle strobes with no gap and 4-bit counter wrap
    code2     = 3'd4;
    enable2   = 1'b1;
    in_valid2 = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      tick();
      chk("s_out", {24'd0, out2},
          (t % 2 == 1) ? 32'h10 : 32'h0);
      chk("s_ov", {31'd0, ov2}, (t % 2 == 1) ? 32'd1 : 32'd0);
      chk("s_cnt", {28'd0, cnt2}, ((t + 1) / 2) % 16);
      if (t % 2 == 0) begin
        chk("s_ready", {31'd0, ready2}, 32'd1);
        chk("s_busy", {31'd0, busy2}, 32'd0);
      end
    end
    in_valid2 = 1'b0;
    tick();
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
